// File: rtl/frame_buffer_if.sv
// Bundle between the drawing logic / LED driver (master) and frame_buffer_ctrl (slave).
// A pixel write transfers on a rising clk edge where wr_valid && wr_ready. Once wr_valid is raised, x, y and the colour are held until that edge.
interface frame_buffer_if #(
    parameter int COLS = 16,
    parameter int ROWS = 8,
    parameter int BPC  = 8
);
    localparam int XW = $clog2(COLS);
    localparam int YW = $clog2(ROWS);
    localparam int PW = 3 * BPC;

    logic [XW-1:0]      x;
    logic [YW-1:0]      y;
    logic [BPC-1:0]     red;
    logic [BPC-1:0]     green;
    logic [BPC-1:0]     blue;
    logic               wr_valid;
    logic               wr_ready;
    logic               fill_req;
    logic               flip_req;
    logic               vsync;
    logic [YW-1:0]      rd_row;
    logic [COLS*PW-1:0] rd_data;
    logic               page;
    logic               busy;
    logic               flip_done;
    logic               oob;
    logic [1:0]         state;

    modport master (
        output x, y, red, green, blue, wr_valid, fill_req, flip_req, vsync, rd_row,
        input  wr_ready, rd_data, page, busy, flip_done, oob, state
    );

    modport slave (
        input  x, y, red, green, blue, wr_valid, fill_req, flip_req, vsync, rd_row,
        output wr_ready, rd_data, page, busy, flip_done, oob, state
    );
endinterface

// File: rtl/frame_buffer_ctrl.sv
// Double-buffered LED frame buffer: pixel writes and hardware fill go to the back page,
// full rows are read from the front page, and the pages swap only on vsync.
module frame_buffer_ctrl #(
    parameter int COLS = 16,
    parameter int ROWS = 8,
    parameter int BPC  = 8
) (
    input  logic          clk,
    input  logic          rst,
    frame_buffer_if.slave bus
);
    localparam int XW   = $clog2(COLS);
    localparam int YW   = $clog2(ROWS);
    localparam int PW   = 3 * BPC;
    localparam int NPIX = COLS * ROWS;
    localparam int CW   = $clog2(NPIX);

    typedef enum logic [1:0] {
        LOAD       = 2'd0,
        FILL       = 2'd1,
        WAIT_VSYNC = 2'd2
    } state_t;

    state_t state, next_state;

    logic [PW-1:0]      mem [2][ROWS][COLS];
    logic               page;
    logic               flip_pending;
    logic               flip_done_q;
    logic               oob_q;
    logic [CW-1:0]      fill_cnt;
    logic [PW-1:0]      fill_color;
    logic [COLS*PW-1:0] rd_data_q;

    logic               wr_ready;
    logic               accept;
    logic               we;
    logic [XW-1:0]      wr_x;
    logic [YW-1:0]      wr_y;
    logic [PW-1:0]      wr_pix;

    logic [PW-1:0]      pixel;
    logic               in_range;
    logic               fill_last;
    logic               rd_ok;

    assign pixel     = {bus.red, bus.green, bus.blue};
    assign in_range  = (int'(bus.x) < COLS) && (int'(bus.y) < ROWS);
    assign fill_last = (int'(fill_cnt) == NPIX - 1);
    assign rd_ok     = int'(bus.rd_row) < ROWS;

    always_ff @(posedge clk) begin
        if (rst) state <= LOAD;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        wr_ready   = 1'b0;
        accept     = 1'b0;
        we         = 1'b0;
        wr_x       = '0;
        wr_y       = '0;
        wr_pix     = '0;
        case (state)
            LOAD: begin
                wr_ready = !rst;
                accept   = bus.wr_valid && wr_ready;
                if (accept && in_range) begin
                    we     = 1'b1;
                    wr_x   = bus.x;
                    wr_y   = bus.y;
                    wr_pix = pixel;
                end
                // A simultaneous fill wins; the flip is parked as pending.
                if (bus.fill_req)      next_state = FILL;
                else if (bus.flip_req) next_state = WAIT_VSYNC;
            end
            FILL: begin
                we     = 1'b1;
                wr_x   = XW'(int'(fill_cnt) % COLS);
                wr_y   = YW'(int'(fill_cnt) / COLS);
                wr_pix = fill_color;
                if (fill_last)
                    next_state = (flip_pending || bus.flip_req) ? WAIT_VSYNC : LOAD;
            end
            WAIT_VSYNC: begin
                if (bus.vsync) next_state = LOAD;
            end
            default: next_state = LOAD;
        endcase
        if (rst) begin
            next_state = LOAD;
            we         = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem[page][wr_y][wr_x] <= wr_pix;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            for (int c = 0; c < COLS; c++)
                rd_data_q[c*PW +: PW] <= rd_ok ? mem[~page][bus.rd_row][c] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            page         <= 1'b0;
            flip_pending <= 1'b0;
            flip_done_q  <= 1'b0;
            oob_q        <= 1'b0;
            fill_cnt     <= '0;
            fill_color   <= '0;
        end else begin
            flip_done_q <= 1'b0;
            oob_q       <= accept && !in_range;
            case (state)
                LOAD: begin
                    if (bus.fill_req) begin
                        fill_cnt     <= '0;
                        fill_color   <= pixel;
                        flip_pending <= bus.flip_req;
                    end
                end
                FILL: begin
                    if (fill_last) begin
                        flip_pending <= 1'b0;
                    end else begin
                        fill_cnt <= fill_cnt + 1'b1;
                        if (bus.flip_req) flip_pending <= 1'b1;
                    end
                end
                WAIT_VSYNC: begin
                    if (bus.vsync) begin
                        page        <= ~page;
                        flip_done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.wr_ready  = wr_ready;
    assign bus.rd_data   = rd_data_q;
    assign bus.page      = page;
    assign bus.busy      = (state != LOAD) || flip_pending;
    assign bus.flip_done = flip_done_q;
    assign bus.oob       = oob_q;
    assign bus.state     = state;
endmodule
